// File: rtl/gray_ptr_counter.sv
// Registered up/down Gray-code pointer with synchronous load, wrap or saturate at the
// range ends, and a combinational look-ahead of the next Gray value.
module gray_ptr_counter #(
  parameter int             PTR         = 8,
  parameter int             WRAP_MODE   = 1,
  parameter logic [PTR:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic         load_is_gray,
  input  logic [PTR:0] load_value,
  output logic [PTR:0] bin_value,
  output logic [PTR:0] gray_value,
  output logic [PTR:0] gray_next,
  output logic         wrap
);

  localparam bit           WRAP_EN = (WRAP_MODE != 0);
  localparam logic [PTR:0] ONE     = {{PTR{1'b0}}, 1'b1};

  function automatic logic [PTR:0] gray_to_bin(input logic [PTR:0] g);
    logic [PTR:0] b;
    b[PTR] = g[PTR];
    for (int i = PTR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR:0] r_bin;
  logic [PTR:0] r_gray;
  logic         r_wrap;

  logic [PTR:0] w_load_bin;
  logic [PTR:0] w_step_bin;
  logic [PTR:0] w_next_bin;
  logic         w_at_edge;
  logic         w_next_wrap;

  assign w_load_bin = load_is_gray ? gray_to_bin(load_value) : load_value;
  assign w_at_edge  = dir ? (&r_bin) : ~(|r_bin);

  // Natural overflow of the adder gives the modular wrap; saturate mode holds instead.
  always_comb begin
    w_step_bin = dir ? (r_bin + ONE) : (r_bin - ONE);
    if (w_at_edge && !WRAP_EN) begin
      w_step_bin = r_bin;
    end
  end

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (rst) begin
      w_next_bin = RESET_VALUE;
    end else if (load) begin
      w_next_bin = w_load_bin;
    end else if (en) begin
      w_next_bin  = w_step_bin;
      w_next_wrap = w_at_edge;
    end
  end

  assign gray_next = w_next_bin ^ (w_next_bin >> 1);

  // Gray is kept in its own flops so the CDC-facing bus never glitches through logic.
  always_ff @(posedge clk) begin
    r_bin  <= w_next_bin;
    r_gray <= gray_next;
    r_wrap <= w_next_wrap;
  end

  assign bin_value  = r_bin;
  assign gray_value = r_gray;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Bench for gray_ptr_counter: a wrapping and a saturating instance share one stimulus
// stream and are checked every cycle against an arithmetic model plus literal values.
module tb_gray_ptr_counter;

  localparam int W    = 4;
  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, load_is_gray;
  logic [3:0] load_value;
  logic [3:0] w_bin, w_gray, w_gnext, s_bin, s_gray, s_gnext;
  logic       w_wrap, s_wrap;

  always #5 clk = ~clk;

  gray_ptr_counter #(.PTR(3), .WRAP_MODE(1), .RESET_VALUE(4'd0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_is_gray(load_is_gray),
    .load_value(load_value), .bin_value(w_bin), .gray_value(w_gray), .gray_next(w_gnext),
    .wrap(w_wrap)
  );

  gray_ptr_counter #(.PTR(3), .WRAP_MODE(0), .RESET_VALUE(4'd3)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_is_gray(load_is_gray),
    .load_value(load_value), .bin_value(s_bin), .gray_value(s_gray), .gray_next(s_gnext),
    .wrap(s_wrap)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int g_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int b_of_gray(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic void predict(input int cur, input bit wm, input int rv,
                                  output int nb, output bit nw);
    int t;
    nw = 1'b0;
    nb = cur;
    if (rst) nb = rv;
    else if (load) nb = load_is_gray ? b_of_gray(int'(load_value)) : int'(load_value);
    else if (en) begin
      t = dir ? cur + 1 : cur - 1;
      if (t < 0 || t > MAXV) begin
        nw = 1'b1;
        nb = wm ? (t + 16) % 16 : cur;
      end else begin
        nb = t;
      end
    end
  endfunction

  int m_bin_w, m_bin_s;
  bit m_wrap_w, m_wrap_s, m_ok, m_step;

  always @(posedge clk) begin
    int nb_w, nb_s;
    bit nw_w, nw_s;
    predict(m_bin_w, 1'b1, 0, nb_w, nw_w);
    predict(m_bin_s, 1'b0, 3, nb_s, nw_s);
    m_bin_w  <= nb_w;
    m_wrap_w <= nw_w;
    m_bin_s  <= nb_s;
    m_wrap_s <= nw_s;
    m_step   <= !rst && !load && en;
    if (rst) m_ok <= 1'b1;
  end

  int p_bin_w, p_bin_s;
  int p_gray_w, p_gray_s;

  always @(negedge clk) begin
    int nb;
    bit nw;
    if (m_ok) begin
      chk("w_bin",  int'(w_bin),  m_bin_w);
      chk("w_gray", int'(w_gray), g_of(m_bin_w));
      chk("w_wrap", int'(w_wrap), int'(m_wrap_w));
      predict(m_bin_w, 1'b1, 0, nb, nw);
      chk("w_gray_next", int'(w_gnext), g_of(nb));
      chk("s_bin",  int'(s_bin),  m_bin_s);
      chk("s_gray", int'(s_gray), g_of(m_bin_s));
      chk("s_wrap", int'(s_wrap), int'(m_wrap_s));
      predict(m_bin_s, 1'b0, 3, nb, nw);
      chk("s_gray_next", int'(s_gnext), g_of(nb));
      if (m_step) begin
        chk("w_one_bit_change", $countones(int'(w_gray) ^ p_gray_w), int'(m_bin_w != p_bin_w));
        chk("s_one_bit_change", $countones(int'(s_gray) ^ p_gray_s), int'(m_bin_s != p_bin_s));
      end
    end
    p_bin_w  <= m_bin_w;
    p_bin_s  <= m_bin_s;
    p_gray_w <= int'(w_gray);
    p_gray_s <= int'(s_gray);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; load_is_gray = 1'b0; load_value = 4'd9;

    // Reset wins over load and en, held for two edges.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_w_bin", int'(w_bin), 0);
      chk("rst_w_gray", int'(w_gray), 0);
      chk("rst_w_wrap", int'(w_wrap), 0);
      chk("rst_s_bin", int'(s_bin), 3);
      chk("rst_s_gray", int'(s_gray), 2);
    end

    // Seventeen up-steps: 0..15, then wrap to 0, then 1.
    rst = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("up_walk_bin", int'(w_bin), i % 16);
      chk("up_walk_wrap", int'(w_wrap), int'(i == 16));
      if (i == 15) chk("up_gray15", int'(w_gray), 8);
      if (i == 16) chk("up_gray_wrapped", int'(w_gray), 0);
    end
    chk("sat_top_bin", int'(s_bin), 15);
    chk("sat_top_wrap", int'(s_wrap), 1);

    en = 1'b0;
    tick();
    chk("idle_w_wrap", int'(w_wrap), 0);
    chk("idle_s_wrap", int'(s_wrap), 0);
    chk("idle_w_bin", int'(w_bin), 1);

    // Gray-coded load 1101 -> binary 1001; en is ignored during the load.
    load = 1'b1; load_is_gray = 1'b1; load_value = 4'b1101; en = 1'b1; dir = 1'b1;
    tick();
    chk("gload_bin", int'(w_bin), 9);
    chk("gload_gray", int'(w_gray), 13);
    chk("gload_wrap", int'(w_wrap), 0);
    chk("gload_s_bin", int'(s_bin), 9);
    load = 1'b0; load_is_gray = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    chk("gload_down_bin", int'(w_bin), 8);
    chk("gload_down_gray", int'(w_gray), 12);

    // Saturate at the top for three blocked steps, then step down.
    load = 1'b1; load_value = 4'd15; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold_bin", int'(s_bin), 15);
      chk("sat_hold_gray", int'(s_gray), 8);
      chk("sat_hold_wrap", int'(s_wrap), 1);
      chk("wrap_past_top", int'(w_bin), i);
    end
    dir = 1'b0;
    tick();
    chk("sat_release_bin", int'(s_bin), 14);
    chk("sat_release_wrap", int'(s_wrap), 0);

    // Down boundary at 0.
    load = 1'b1; load_value = 4'd0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    chk("down_wrap_bin", int'(w_bin), 15);
    chk("down_wrap_pulse", int'(w_wrap), 1);
    chk("down_sat_bin", int'(s_bin), 0);
    chk("down_sat_pulse", int'(s_wrap), 1);

    // Look-ahead: at bin 5 stepping up, gray_next is Gray(6) = 0101.
    load = 1'b1; load_value = 4'd5; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #1;
    chk("gnext_lookahead", int'(w_gnext), 5);
    chk("gnext_cur_gray", int'(w_gray), 7);
    tick();
    chk("gnext_landed", int'(w_gray), 5);
    en = 1'b0;
    #1;
    chk("gnext_idle", int'(w_gnext), 5);

    // Reset in the middle of counting.
    load = 1'b1; load_value = 4'd6;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    chk("pre_rst_bin", int'(w_bin), 7);
    rst = 1'b1;
    tick();
    chk("mid_rst_w_bin", int'(w_bin), 0);
    chk("mid_rst_w_wrap", int'(w_wrap), 0);
    chk("mid_rst_s_bin", int'(s_bin), 3);
    rst = 1'b0;
    tick();
    chk("post_rst_w_bin", int'(w_bin), 1);
    chk("post_rst_s_bin", int'(s_bin), 4);

    // Reverse direction on every step.
    for (int i = 0; i < 8; i++) begin
      dir = i[0];
      tick();
      chk("reverse_w_bin", int'(w_bin), (i % 2 == 0) ? 0 : 1);
      chk("reverse_s_bin", int'(s_bin), (i % 2 == 0) ? 3 : 4);
    end

    en = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
